// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcode/funct
// values, ALU function codes (identical to the ALU's own encodings) and the
// controller state enum.
package mips_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    // Special funct values (IR[5:0]) that are not ALU operations
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;

    // ALU function codes; R-type codes equal the MIPS funct field
    localparam logic [5:0] ALU_SLL  = 6'b000000;
    localparam logic [5:0] ALU_SRL  = 6'b000010;
    localparam logic [5:0] ALU_SRA  = 6'b000011;
    localparam logic [5:0] ALU_SLLV = 6'b000100;
    localparam logic [5:0] ALU_SRLV = 6'b000110;
    localparam logic [5:0] ALU_SRAV = 6'b000111;
    localparam logic [5:0] ALU_LUI  = 6'b001111;
    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_ADDU = 6'b100001;
    localparam logic [5:0] ALU_SUB  = 6'b100010;
    localparam logic [5:0] ALU_SUBU = 6'b100011;
    localparam logic [5:0] ALU_AND  = 6'b100100;
    localparam logic [5:0] ALU_OR   = 6'b100101;
    localparam logic [5:0] ALU_XOR  = 6'b100110;
    localparam logic [5:0] ALU_NOR  = 6'b100111;
    localparam logic [5:0] ALU_SLT  = 6'b101010;
    localparam logic [5:0] ALU_SLTU = 6'b101011;
    localparam logic [5:0] ALU_BEQ  = 6'b111000;
    localparam logic [5:0] ALU_BNE  = 6'b111001;
    localparam logic [5:0] ALU_BLEZ = 6'b111010;
    localparam logic [5:0] ALU_BGTZ = 6'b111011;
    localparam logic [5:0] ALU_BGEZ = 6'b111100;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_ALU_WB,
        ST_BRANCH,
        ST_JUMP,
        ST_JR,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_HALT,
        ST_ERROR
    } state_t;

    // R-type funct values the ALU implements directly
    function automatic logic is_alu_funct(input logic [5:0] f);
        case (f)
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV,
            ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR,
            ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_branch_op(input logic [5:0] op);
        case (op)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

    function automatic logic is_imm_op(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
            OP_ORI, OP_XORI, OP_LUI:  return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_alu_func_dec.sv
// Combinational opcode/funct -> ALU function code map. R-type passes funct
// straight through; immediates and branches get their dedicated codes.
module mips_alu_func_dec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [5:0] alu_func
);

    // Map the instruction fields onto the ALU encoding
    always_comb begin
        alu_func = ALU_ADDU;
        case (opcode)
            OP_RTYPE:          alu_func = funct;
            OP_ADDI, OP_ADDIU: alu_func = ALU_ADDU;
            OP_SLTI:           alu_func = ALU_SLT;
            OP_ANDI:           alu_func = ALU_AND;
            OP_ORI:            alu_func = ALU_OR;
            OP_XORI:           alu_func = ALU_XOR;
            OP_LUI:            alu_func = ALU_LUI;
            OP_BEQ:            alu_func = ALU_BEQ;
            OP_BNE:            alu_func = ALU_BNE;
            OP_BLEZ:           alu_func = ALU_BLEZ;
            OP_BGTZ:           alu_func = ALU_BGTZ;
            OP_REGIMM:         alu_func = ALU_BGEZ;
            default:           alu_func = ALU_ADDU;
        endcase
    end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multicycle MIPS control unit. Moore FSM sequencing fetch/decode/execute/
// memory/writeback, driving ALU function code and datapath enables, with a
// bounded memory request/ready handshake.
// Optional feature: define MIPS_CTRL_PERF_EN to add cycle_cnt/instr_cnt.
module mips_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic [5:0]       alu_func,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             halt,
`ifdef MIPS_CTRL_PERF_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
`endif
    output logic             err
);

    localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [5:0]        dec_func;
    logic              mem_state;
    logic              wait_expired;

    // The branch decision (pc_write_cond & alu_zero) is applied in the
    // datapath; the controller only presents the qualified write.
    logic unused_ok;
    assign unused_ok = alu_zero | (CNT_W < 1);

    mips_alu_func_dec u_func_dec (
        .opcode   (opcode),
        .funct    (funct),
        .alu_func (dec_func)
    );

    assign mem_state    = (state_reg == ST_FETCH) || (state_reg == ST_MEM_RD) ||
                          (state_reg == ST_MEM_WR);
    assign wait_expired = (wait_reg == WAIT_W'(MEM_WAIT_MAX - 1));

    // State register and memory wait counter
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_reg <= ST_IDLE;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
        end
    end

    // Next-state logic and Moore output decode
    always_comb begin
        state_next    = state_reg;
        // counter restarts whenever no request is outstanding or one completes
        wait_next     = (mem_state && !mem_ready) ? wait_reg + 1'b1 : '0;
        alu_func      = '0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        mem_req       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'd0;
        halt          = 1'b0;
        err           = 1'b0;
        case (state_reg)
            ST_IDLE: state_next = ST_FETCH;
            ST_FETCH: begin
                mem_req   = 1'b1;
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'd1;
                alu_func  = ALU_ADDU;
                if (mem_ready)         state_next = ST_DECODE;
                else if (wait_expired) state_next = ST_ERROR;
            end
            ST_DECODE: begin
                // branch target PC + (imm << 2) is precomputed into ALUOut
                alu_src_b = 2'd3;
                alu_func  = ALU_ADDU;
                if (opcode == OP_RTYPE) begin
                    if (funct == FN_JR)               state_next = ST_JR;
                    else if (funct == FN_SYSCALL)     state_next = ST_HALT;
                    else if (is_alu_funct(funct))     state_next = ST_EXEC_R;
                    else                              state_next = ST_ERROR;
                end else if (opcode == OP_J)          state_next = ST_JUMP;
                else if (is_branch_op(opcode))        state_next = ST_BRANCH;
                else if (is_imm_op(opcode))           state_next = ST_EXEC_I;
                else if (opcode == OP_LW || opcode == OP_SW)
                                                      state_next = ST_MEM_ADDR;
                else                                  state_next = ST_ERROR;
            end
            ST_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_func   = dec_func;
                state_next = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                // immediates operate on reg A (rs), not on the PC
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                alu_func   = dec_func;
                state_next = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OP_RTYPE);
                state_next = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
                alu_func      = dec_func;
                state_next    = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'd2;
                state_next = ST_FETCH;
            end
            ST_JR: begin
                pc_write   = 1'b1;
                pc_source  = 2'd3;
                state_next = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                alu_func   = ALU_ADDU;
                state_next = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready)         state_next = ST_MEM_WB;
                else if (wait_expired) state_next = ST_ERROR;
            end
            ST_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready)         state_next = ST_FETCH;
                else if (wait_expired) state_next = ST_ERROR;
            end
            ST_HALT:  halt = 1'b1;
            ST_ERROR: err  = 1'b1;
            default:  state_next = ST_ERROR;
        endcase
    end

`ifdef MIPS_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_reg, instr_cnt_reg;
    logic             running, completing;

    assign running    = !(state_reg inside {ST_IDLE, ST_HALT, ST_ERROR});
    assign completing = (state_next == ST_FETCH) &&
                        (state_reg inside {ST_ALU_WB, ST_MEM_WB, ST_MEM_WR,
                                           ST_BRANCH, ST_JUMP, ST_JR});

    // Free-running, wrapping performance counters
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            cycle_cnt_reg <= '0;
            instr_cnt_reg <= '0;
        end else begin
            if (running)    cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
            if (completing) instr_cnt_reg <= instr_cnt_reg + 1'b1;
        end
    end

    assign cycle_cnt = cycle_cnt_reg;
    assign instr_cnt = instr_cnt_reg;
`endif

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed testbench for mips_ctrl_fsm. Stimulus pushes the expected output
// vector of each cycle into a scoreboard queue; a monitor on the falling
// edge pops and compares. Perf counters are checked when MIPS_CTRL_PERF_EN
// is defined.
`timescale 1ns/1ps
module tb_mips_ctrl_fsm;

    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_LUI  = 6'b001111;

    localparam logic [5:0] I_OPS [7] = '{6'b001000, 6'b001001, 6'b001010, 6'b001100,
                                         6'b001101, 6'b001110, 6'b001111};
    localparam logic [5:0] I_FNS [7] = '{F_ADDU, F_ADDU, F_SLT, F_AND, F_OR, F_XOR, F_LUI};
    localparam logic [5:0] B_OPS [6] = '{6'b000100, 6'b000100, 6'b000101, 6'b000110,
                                         6'b000111, 6'b000001};
    localparam logic [5:0] B_FNS [6] = '{6'b111000, 6'b111000, 6'b111001, 6'b111010,
                                         6'b111011, 6'b111100};

    logic       clk = 1'b0;
    logic       rst_b = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [5:0] alu_func;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_req, mem_read, mem_write, i_or_d;
    logic       ir_write, reg_write, reg_dst, mem_to_reg;
    logic       pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic       halt, err;
`ifdef MIPS_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    typedef struct packed {
        logic       halt;
        logic       err;
        logic [5:0] alu_func;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
    } outs_t;

    typedef struct {
        string       name;
        outs_t       exp;
        bit          chk_perf;
        logic [31:0] exp_cyc;
        logic [31:0] exp_ins;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    passed = 0;
    item_t mon_it;
    outs_t mon_act;

    mips_ctrl_fsm #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .opcode        (opcode),
        .funct         (funct),
        .alu_zero      (alu_zero),
        .mem_ready     (mem_ready),
        .alu_func      (alu_func),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .mem_req       (mem_req),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .halt          (halt),
`ifdef MIPS_CTRL_PERF_EN
        .cycle_cnt     (cycle_cnt),
        .instr_cnt     (instr_cnt),
`endif
        .err           (err)
    );

    always #5 clk = ~clk;

    // ---------------- expected output vectors per state ----------------
    function automatic outs_t o_zero();
        outs_t o;
        o = '0;
        return o;
    endfunction
    function automatic outs_t o_fetch();
        outs_t o;
        o = '0; o.mem_req = 1; o.mem_read = 1; o.ir_write = 1; o.pc_write = 1;
        o.alu_src_b = 2'd1; o.alu_func = F_ADDU;
        return o;
    endfunction
    function automatic outs_t o_decode();
        outs_t o;
        o = '0; o.alu_src_b = 2'd3; o.alu_func = F_ADDU;
        return o;
    endfunction
    function automatic outs_t o_exec_r(input logic [5:0] f);
        outs_t o;
        o = '0; o.alu_src_a = 1; o.alu_func = f;
        return o;
    endfunction
    function automatic outs_t o_exec_i(input logic [5:0] f);
        outs_t o;
        o = '0; o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_func = f;
        return o;
    endfunction
    function automatic outs_t o_alu_wb(input logic rd);
        outs_t o;
        o = '0; o.reg_write = 1; o.reg_dst = rd;
        return o;
    endfunction
    function automatic outs_t o_branch(input logic [5:0] f);
        outs_t o;
        o = '0; o.alu_src_a = 1; o.pc_write_cond = 1; o.pc_source = 2'd1; o.alu_func = f;
        return o;
    endfunction
    function automatic outs_t o_jump(input logic [1:0] src);
        outs_t o;
        o = '0; o.pc_write = 1; o.pc_source = src;
        return o;
    endfunction
    function automatic outs_t o_mem_addr();
        outs_t o;
        o = '0; o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_func = F_ADDU;
        return o;
    endfunction
    function automatic outs_t o_mem_rd();
        outs_t o;
        o = '0; o.mem_req = 1; o.mem_read = 1; o.i_or_d = 1;
        return o;
    endfunction
    function automatic outs_t o_mem_wb();
        outs_t o;
        o = '0; o.mem_to_reg = 1; o.reg_write = 1;
        return o;
    endfunction
    function automatic outs_t o_mem_wr();
        outs_t o;
        o = '0; o.mem_req = 1; o.mem_write = 1; o.i_or_d = 1;
        return o;
    endfunction
    function automatic outs_t o_halt();
        outs_t o;
        o = '0; o.halt = 1;
        return o;
    endfunction
    function automatic outs_t o_err();
        outs_t o;
        o = '0; o.err = 1;
        return o;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic push(input string name, input outs_t e, input bit pf,
                        input logic [31:0] ec, input logic [31:0] ei);
        item_t it;
        it.name = name; it.exp = e; it.chk_perf = pf; it.exp_cyc = ec; it.exp_ins = ei;
        sb.push_back(it);
    endtask

    // advance one cycle, drive mem_ready for it, record its expected outputs
    task automatic cyc(input string name, input outs_t e, input logic rdy);
        @(posedge clk); #1;
        mem_ready = rdy;
        push(name, e, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic fetch(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input int waits);
        for (int i = 0; i < waits; i++) cyc({tag, "_fetch_wait"}, o_fetch(), 1'b0);
        cyc({tag, "_fetch"}, o_fetch(), 1'b1);
        opcode = op;
        funct  = fn;
    endtask

    // assert reset mid-cycle, hold over one edge, release; FETCH follows next edge
    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst_b = 1'b1;
        push({tag, "_rst_abort"}, o_zero(), 1'b0, 32'd0, 32'd0);
        cyc({tag, "_rst_idle"}, o_zero(), 1'b0);
        rst_b = 1'b0;
    endtask

    task automatic do_addu(input string tag);
        fetch(tag, 6'b000000, F_ADDU, 0);
        mem_ready = 1'b1;
        cyc({tag, "_decode"}, o_decode(), 1'b1);
        cyc({tag, "_exec_r"}, o_exec_r(F_ADDU), 1'b1);
        cyc({tag, "_alu_wb"}, o_alu_wb(1'b1), 1'b1);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_it  = sb.pop_front();
            mon_act = '{halt, err, alu_func, alu_src_a, alu_src_b, mem_req, mem_read,
                        mem_write, i_or_d, ir_write, reg_write, reg_dst, mem_to_reg,
                        pc_write, pc_write_cond, pc_source};
            checks++;
            if (mon_act === mon_it.exp) passed++;
            else $display("FAIL %s: outputs got %h required %h", mon_it.name, mon_act, mon_it.exp);
`ifdef MIPS_CTRL_PERF_EN
            if (mon_it.chk_perf) begin
                checks++;
                if (cycle_cnt === mon_it.exp_cyc) passed++;
                else $display("FAIL %s_cycle_cnt: got %0d required %0d", mon_it.name, cycle_cnt, mon_it.exp_cyc);
                checks++;
                if (instr_cnt === mon_it.exp_ins) passed++;
                else $display("FAIL %s_instr_cnt: got %0d required %0d", mon_it.name, instr_cnt, mon_it.exp_ins);
            end
`endif
        end
    end

    // ---------------- directed script ----------------
    initial begin
        // reset state, then release: FETCH on the next edge
        cyc("reset_state", o_zero(), 1'b0);
        rst_b = 1'b0;

        // three addu with mem_ready tied high (ignored outside requests)
        do_addu("addu0");
        do_addu("addu1");
        do_addu("addu2");

        // 4th fetch carries the perf snapshot (12 cycles, 3 instructions); j follows
        @(posedge clk); #1;
        mem_ready = 1'b1;
        push("perf_fetch", o_fetch(), 1'b1, 32'd12, 32'd3);
        opcode = 6'b000010; funct = 6'd0;
        cyc("j_decode", o_decode(), 1'b0);
        cyc("j_jump", o_jump(2'd2), 1'b0);

        // jr
        fetch("jr", 6'b000000, 6'b001000, 0);
        cyc("jr_decode", o_decode(), 1'b0);
        cyc("jr_jr", o_jump(2'd3), 1'b0);

        // immediate instructions
        for (int i = 0; i < 7; i++) begin
            fetch("imm", I_OPS[i], 6'd0, 0);
            cyc("imm_decode", o_decode(), 1'b0);
            cyc("imm_exec_i", o_exec_i(I_FNS[i]), 1'b0);
            cyc("imm_alu_wb", o_alu_wb(1'b0), 1'b0);
        end

        // further R-type functs
        fetch("subu", 6'b000000, F_SUBU, 0);
        cyc("subu_decode", o_decode(), 1'b0);
        cyc("subu_exec_r", o_exec_r(F_SUBU), 1'b0);
        cyc("subu_alu_wb", o_alu_wb(1'b1), 1'b0);
        fetch("slt", 6'b000000, F_SLT, 0);
        cyc("slt_decode", o_decode(), 1'b0);
        cyc("slt_exec_r", o_exec_r(F_SLT), 1'b0);
        cyc("slt_alu_wb", o_alu_wb(1'b1), 1'b0);

        // branches, alu_zero alternating (outputs identical either way)
        for (int i = 0; i < 6; i++) begin
            alu_zero = (i % 2 == 0);
            fetch("br", B_OPS[i], 6'd0, 0);
            cyc("br_decode", o_decode(), 1'b0);
            cyc("br_exec", o_branch(B_FNS[i]), 1'b0);
        end
        alu_zero = 1'b0;

        // lw with 3 wait cycles in MEM_RD: mem_req held 4 cycles
        fetch("lw", 6'b100011, 6'd0, 1);
        cyc("lw_decode", o_decode(), 1'b0);
        cyc("lw_mem_addr", o_mem_addr(), 1'b0);
        for (int i = 0; i < 3; i++) cyc("lw_mem_rd_wait", o_mem_rd(), 1'b0);
        cyc("lw_mem_rd", o_mem_rd(), 1'b1);
        cyc("lw_mem_wb", o_mem_wb(), 1'b0);

        // sw zero-wait
        fetch("sw", 6'b101011, 6'd0, 0);
        cyc("sw_decode", o_decode(), 1'b0);
        cyc("sw_mem_addr", o_mem_addr(), 1'b0);
        cyc("sw_mem_wr", o_mem_wr(), 1'b1);

        // sw stalled, reset asserted while mem_req/mem_write high
        fetch("swab", 6'b101011, 6'd0, 0);
        cyc("swab_decode", o_decode(), 1'b0);
        cyc("swab_mem_addr", o_mem_addr(), 1'b0);
        cyc("swab_mem_wr", o_mem_wr(), 1'b0);
        do_reset("swab");
        fetch("after_rst", 6'b000000, F_ADDU, 0);
        cyc("after_rst_decode", o_decode(), 1'b0);
        cyc("after_rst_exec_r", o_exec_r(F_ADDU), 1'b0);
        cyc("after_rst_alu_wb", o_alu_wb(1'b1), 1'b0);

        // illegal opcode -> ERROR, terminal
        fetch("illop", 6'b111111, 6'd0, 0);
        cyc("illop_decode", o_decode(), 1'b0);
        for (int i = 0; i < 3; i++) cyc("illop_err", o_err(), 1'b1);
        do_reset("illop");

        // R-type with a funct outside the ALU set -> ERROR
        fetch("illfn", 6'b000000, 6'b000001, 0);
        cyc("illfn_decode", o_decode(), 1'b0);
        cyc("illfn_err", o_err(), 1'b0);
        do_reset("illfn");

        // syscall -> HALT, terminal
        fetch("sysc", 6'b000000, 6'b001100, 0);
        cyc("sysc_decode", o_decode(), 1'b0);
        for (int i = 0; i < 3; i++) cyc("sysc_halt", o_halt(), 1'b1);
        do_reset("sysc");

        // fetch never answered: 15 wait cycles then ERROR, even if ready later
        for (int i = 0; i < 15; i++) cyc("timeout_wait", o_fetch(), 1'b0);
        for (int i = 0; i < 3; i++) cyc("timeout_err", o_err(), 1'b1);
        do_reset("timeout");
        cyc("final_fetch", o_fetch(), 1'b1);

        @(negedge clk); #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
